// File: rtl/cnt_seg_scan.sv
// cnt_seg_scan
//   Display stage for a 4-bit free-running counter. It registers the count and
//   splits it into two decimal digits (00..15). It then scans a time-multiplexed
//   two-digit 7-segment display. The displayed value is latched only at frame
//   boundaries, so one frame never mixes digits from two different counts.
//   It also flags every 15->0 counter wrap and keeps a saturating wrap tally.
//
// Parameters
//   REFRESH_DIV : clock cycles each digit stays selected (2..65535)
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   cnt_in     : [3:0] count from the upstream counter (synchronous to clk)
//   seg        : [6:0] segment drive, active-high, {g,f,e,d,c,b,a}
//   an         : [1:0] digit enable, active-low; an[0]=ones, an[1]=tens
//   wrap_pulse : one-cycle pulse per detected 15->0 wrap
//   wrap_cnt   : [7:0] wraps since reset, saturating at 255
module cnt_seg_scan #(
  parameter int REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_pulse,
  output logic [7:0] wrap_cnt
);

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [3:0]  cnt_q;
  logic [3:0]  cnt_prev;
  logic [3:0]  disp_q;
  logic [15:0] div;
  state_t      state;

  logic        tens;
  logic [3:0]  ones;
  logic        wrap_det;

  // Segment pattern for one decimal digit; anything outside 0..9 is blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Decimal split of the frame-latched value
  always_comb begin
    tens = (disp_q >= 4'd10);
    ones = tens ? (disp_q - 4'd10) : disp_q;
  end

  assign wrap_det = (cnt_prev == 4'd15) && (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= 4'd0;
      cnt_prev   <= 4'd0;
      disp_q     <= 4'd0;
      div        <= 16'd0;
      state      <= DIG0;
      seg        <= 7'h00;
      an         <= 2'b11;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= 8'd0;
    end else begin
      // Input stage
      cnt_q    <= cnt_in;
      cnt_prev <= cnt_q;

      // Scan sequencing; a new value is taken only when the tens slot ends,
      // so the following ones+tens pair always comes from one count.
      if (div == DIV_LAST) begin
        div <= 16'd0;
        if (state == DIG1) begin
          state  <= DIG0;
          disp_q <= cnt_q;
        end else begin
          state <= DIG1;
        end
      end else begin
        div <= div + 16'd1;
      end

      // Output register; lags the scan state by one cycle.
      // The tens digit is either blank or "1".
      if (state == DIG0) begin
        an  <= 2'b10;
        seg <= seg_code(ones);
      end else begin
        an  <= 2'b01;
        seg <= tens ? seg_code(4'd1) : 7'h00;
      end

      // Wrap detection and saturating tally
      wrap_pulse <= wrap_det;
      if (wrap_det && (wrap_cnt != 8'hFF)) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

endmodule
